// File: rtl/arm_mainfsm_if.sv
// Control bundle between the multicycle ARM main FSM (master) and the
// datapath (slave): instruction fields and memory-ready in, enables/selects out.
interface arm_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemRdy;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemRdy,
    output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUOp, State
  );

  modport slave (
    output Op, Funct, MemRdy,
    input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUOp, State
  );
endinterface

// File: rtl/arm_mainfsm.sv
// Main control FSM for the multicycle ARM datapath: fetch/decode/execute/
// memory/writeback sequencing with MemRdy stalls in FETCH, MEMRD and MEMWR.
module arm_mainfsm #(
  parameter bit UNK_TRAP = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  arm_mainfsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (bus.MemRdy) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (bus.MemRdy) state_d = S_MEMWB;
      S_MEMWR:    if (bus.MemRdy) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      // UNKNOWN and any stray encoding share the trap/recover policy
      default:    state_d = UNK_TRAP ? S_UNKNOWN : S_FETCH;
    endcase
  end

  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.IRWrite   = bus.MemRdy;
        bus.NextPC    = bus.MemRdy;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_MEMADR:   bus.ALUSrcB = 2'b01;
      S_MEMRD:    bus.AdrSrc  = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      S_EXECUTER: bus.ALUOp = 1'b1;
      S_EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      S_ALUWB:    bus.RegW = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.State = state_q;

endmodule
